// File: rtl/serdes_seq_pkg.sv
// Shared types and sizing helpers for the serdes encrypt sequencer.
// Sequencer states and the counter-width functions used by the top level.
package serdes_seq_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      SHIFT     = 3'd2,
      WAIT_DONE = 3'd3,
      OUTPUT    = 3'd4
   } seq_state_t;

   // One spare bit so the bit index can be compared against WORD_W without wrapping.
   function automatic int shift_cnt_w(input int word_w, input int cipher_lat);
      return $clog2(word_w + cipher_lat) + 1;
   endfunction

   function automatic int timeout_cnt_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/serdes_encrypt_sequencer_if.sv
// Operand-in / cipher-out valid-ready bus of the serdes encrypt sequencer.
// master = bus-side producer/consumer, slave = sequencer.
interface serdes_encrypt_sequencer_if #(
   parameter int WORD_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_a;
   logic [WORD_W-1:0] in_b;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/serdes_key_reg.sv
// Key register for the encryptor core: async reset value, load, and rotate-left-by-one.
// Load has priority over rotate; the two never coincide in normal sequencing.
module serdes_key_reg #(
   parameter int               KEY_W     = 8,
   parameter logic [KEY_W-1:0] KEY_RESET = {KEY_W{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [KEY_W-1:0] load_val,
   input  logic             rot_en,
   output logic [KEY_W-1:0] key
);

   logic [KEY_W-1:0] key_r;

   // Key storage: load, rotate or hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_r <= KEY_RESET;
      end else if (load) begin
         key_r <= load_val;
      end else if (rot_en) begin
         key_r <= {key_r[KEY_W-2:0], key_r[KEY_W-1]};
      end else begin
         key_r <= key_r;
      end
   end

   assign key = key_r;

endmodule

// File: rtl/serdes_encrypt_sequencer.sv
// Sequences one serial encryptor core per word: latches operands, streams them LSB-first,
// reassembles the cipher stream and hands the word out over valid/ready.
module serdes_encrypt_sequencer
   import serdes_seq_pkg::*;
#(
   parameter int               WORD_W     = 8,
   parameter int               KEY_W      = 8,
   parameter int               CIPHER_LAT = 1,
   parameter int               TIMEOUT    = 15,
   parameter logic [KEY_W-1:0] KEY_RESET  = 8'h00,
   parameter bit               KEY_ROTATE = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   serdes_encrypt_sequencer_if.slave   bus,
   input  logic                        key_wr,
   input  logic [KEY_W-1:0]            key_in,
   output logic                        busy,
   output logic                        err_timeout,
   output logic                        core_start,
   output logic                        core_a_bit,
   output logic                        core_b_bit,
   output logic [KEY_W-1:0]            core_key,
   input  logic                        core_cipher,
   input  logic                        core_done
);

   localparam int SHIFT_LEN = WORD_W + CIPHER_LAT;
   localparam int KW        = shift_cnt_w(WORD_W, CIPHER_LAT);
   localparam int TW        = timeout_cnt_w(TIMEOUT);

   seq_state_t        state_r;
   seq_state_t        state_nx_s;
   logic [KW-1:0]     k_r;
   logic [KW-1:0]     k_nx_s;
   logic [TW-1:0]     tmo_r;
   logic [WORD_W-1:0] a_sr_r;
   logic [WORD_W-1:0] b_sr_r;
   logic [WORD_W-1:0] cap_r;
   logic [WORD_W-1:0] out_data_r;
   logic              done_lat_r;
   logic              in_ready_r;
   logic              out_valid_r;
   logic              busy_r;
   logic              err_r;
   logic              start_r;
   logic              a_bit_r;
   logic              b_bit_r;
   logic              accept_s;
   logic              deliver_s;
   logic              abort_s;
   logic              emit_s;

   // in_ready_r is high exactly while the state register holds IDLE
   assign accept_s  = bus.in_valid & in_ready_r;
   assign deliver_s = bus.out_ready & out_valid_r;

   // Next-state, bit index of the coming cycle, and operand-bit emit decision
   always_comb begin
      state_nx_s = state_r;
      abort_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nx_s = START;
            else          state_nx_s = IDLE;
         end
         START: state_nx_s = SHIFT;
         SHIFT: begin
            if (k_r == KW'(SHIFT_LEN - 1)) state_nx_s = WAIT_DONE;
            else                           state_nx_s = SHIFT;
         end
         WAIT_DONE: begin
            if (done_lat_r | core_done) begin
               state_nx_s = OUTPUT;
            end else if (tmo_r == TW'(TIMEOUT - 1)) begin
               state_nx_s = IDLE;
               abort_s    = 1'b1;
            end else begin
               state_nx_s = WAIT_DONE;
            end
         end
         OUTPUT: begin
            if (deliver_s) state_nx_s = IDLE;
            else           state_nx_s = OUTPUT;
         end
         default: state_nx_s = IDLE;
      endcase

      if (state_r == SHIFT) k_nx_s = k_r + 1'b1;
      else                  k_nx_s = {KW{1'b0}};

      if ((state_nx_s == SHIFT) && (k_nx_s < KW'(WORD_W))) emit_s = 1'b1;
      else                                                 emit_s = 1'b0;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nx_s;
   end

   // Operand shifters, cipher capture, bit/timeout counters and done latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_r     <= {WORD_W{1'b0}};
         b_sr_r     <= {WORD_W{1'b0}};
         cap_r      <= {WORD_W{1'b0}};
         k_r        <= {KW{1'b0}};
         tmo_r      <= {TW{1'b0}};
         done_lat_r <= 1'b0;
      end else if (accept_s) begin
         a_sr_r     <= bus.in_a;
         b_sr_r     <= bus.in_b;
         cap_r      <= {WORD_W{1'b0}};
         k_r        <= {KW{1'b0}};
         tmo_r      <= {TW{1'b0}};
         done_lat_r <= 1'b0;
      end else begin
         if (emit_s) begin
            a_sr_r <= {1'b0, a_sr_r[WORD_W-1:1]};
            b_sr_r <= {1'b0, b_sr_r[WORD_W-1:1]};
         end
         // Cipher bits enter at the MSB so the first captured bit ends up at bit 0
         if (state_r == SHIFT) begin
            k_r <= k_nx_s;
            if (k_r >= KW'(CIPHER_LAT)) cap_r <= {core_cipher, cap_r[WORD_W-1:1]};
         end
         if (state_r == WAIT_DONE) tmo_r <= tmo_r + 1'b1;
         if (((state_r == SHIFT) || (state_r == WAIT_DONE)) && core_done) done_lat_r <= 1'b1;
      end
   end

   // Registered bus and core-control outputs, decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         start_r     <= 1'b0;
         a_bit_r     <= 1'b0;
         b_bit_r     <= 1'b0;
         err_r       <= 1'b0;
         out_data_r  <= {WORD_W{1'b0}};
      end else begin
         in_ready_r  <= (state_nx_s == IDLE);
         out_valid_r <= (state_nx_s == OUTPUT);
         busy_r      <= (state_nx_s != IDLE);
         start_r     <= (state_nx_s == START);
         a_bit_r     <= emit_s & a_sr_r[0];
         b_bit_r     <= emit_s & b_sr_r[0];
         if (abort_s) err_r <= 1'b1;
         if ((state_r == WAIT_DONE) && (state_nx_s == OUTPUT)) out_data_r <= cap_r;
      end
   end

   serdes_key_reg #(
      .KEY_W     (KEY_W),
      .KEY_RESET (KEY_RESET)
   ) u_key_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (key_wr & (state_r == IDLE)),
      .load_val (key_in),
      .rot_en   (KEY_ROTATE & deliver_s),
      .key      (core_key)
   );

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign busy          = busy_r;
   assign err_timeout   = err_r;
   assign core_start    = start_r;
   assign core_a_bit    = a_bit_r;
   assign core_b_bit    = b_bit_r;

endmodule
